// File: rtl/count_seg_display.sv
// Iterative double-dabble BCD converter for a 9-bit count, time-multiplexed onto a 4-digit 7-segment display.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (ones digit is always shown).
module count_seg_display #(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  count,
  input  logic        led_in,
  output logic [7:0]  seg,
  output logic [3:0]  seg_en,
  output logic [11:0] bcd,
  output logic        upd,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  localparam logic [16:0] PRESC_MAX = 17'(SCAN_DIV - 1);

  state_t      state, state_nx;
  logic [8:0]  count_q, conv_src;
  logic [20:0] sr, sr_adj;
  logic [3:0]  iter;
  logic [16:0] presc;
  logic [1:0]  dig;
  logic [3:0]  nib;
  logic        blank;
  logic [6:0]  enc;

  assign busy = (state != IDLE);

  // Add-3 correction on each BCD nibble before the shift
  always_comb begin
    sr_adj = sr;
    if (sr[20:17] >= 4'd5) sr_adj[20:17] = sr[20:17] + 4'd3;
    if (sr[16:13] >= 4'd5) sr_adj[16:13] = sr[16:13] + 4'd3;
    if (sr[12:9]  >= 4'd5) sr_adj[12:9]  = sr[12:9]  + 4'd3;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count_q != conv_src) state_nx = CONV;
      CONV:    if (iter == 4'd8) state_nx = LATCH;
      LATCH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count_q  <= '0;
      conv_src <= '0;
      sr       <= '0;
      iter     <= '0;
      bcd      <= '0;
      upd      <= 1'b0;
    end else begin
      state   <= state_nx;
      count_q <= count;
      upd     <= 1'b0;
      case (state)
        IDLE: begin
          if (count_q != conv_src) begin
            conv_src <= count_q;
            sr       <= {12'b0, count_q};
            iter     <= '0;
          end
        end
        CONV: begin
          sr   <= sr_adj << 1;
          iter <= iter + 4'd1;
        end
        LATCH: begin
          bcd <= sr[20:9];
          upd <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Digit source is always the latched bcd, never the shift register
  always_comb begin
    case (dig)
      2'd0:    nib = bcd[3:0];
      2'd1:    nib = bcd[7:4];
      2'd2:    nib = bcd[11:8];
      default: nib = 4'd0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (dig)
      2'd0:    blank = 1'b0;
      2'd1:    blank = (bcd[11:4] == 8'd0);
      2'd2:    blank = (bcd[11:8] == 4'd0);
      default: blank = 1'b1;
    endcase
`else
    blank = 1'b0;
`endif
    case (nib)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      dig    <= '0;
      seg    <= '0;
      seg_en <= '0;
    end else begin
      if (presc == PRESC_MAX) begin
        presc <= '0;
        dig   <= dig + 2'd1;
      end else begin
        presc <= presc + 17'd1;
      end
      seg_en <= 4'b0001 << dig;
      seg    <= {(dig == 2'd0) ? led_in : 1'b0, blank ? 7'h00 : enc};
    end
  end

endmodule

// File: tb/tb_count_seg_display.sv
// Directed self-checking bench for count_seg_display: conversion table, scan order, mid-conversion change, async reset.
module tb_count_seg_display;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  count;
  logic        led_in;
  logic [7:0]  seg;
  logic [3:0]  seg_en;
  logic [11:0] bcd;
  logic        upd;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  count_seg_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .count  (count),
    .led_in (led_in),
    .seg    (seg),
    .seg_en (seg_en),
    .bcd    (bcd),
    .upd    (upd),
    .busy   (busy)
  );

  typedef struct {
    logic [8:0]  cnt;
    logic [11:0] exp_bcd;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Applies v before the next edge and observes 20 edges
  task automatic run_conv(input logic [8:0] v, output int first_upd, output int n_upd,
                          output int n_busy, output logic [11:0] bcd_seen);
    first_upd = 0;
    n_upd     = 0;
    n_busy    = 0;
    bcd_seen  = 'x;
    @(negedge clk);
    count = v;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #1;
      if (upd) begin
        n_upd++;
        if (first_upd == 0) first_upd = cyc;
        bcd_seen = bcd;
      end
      if (busy) n_busy++;
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [3:0] en, input logic led);
    case (en)
      4'b0001: exp_seg = {led, 7'h07};
      4'b0010: exp_seg = 8'h4F;
      4'b0100: exp_seg = 8'h06;
`ifdef LEADING_ZERO_BLANK_EN
      4'b1000: exp_seg = 8'h00;
`else
      4'b1000: exp_seg = 8'h3F;
`endif
      default: exp_seg = 8'hEE;
    endcase
  endfunction

  initial begin
    int          fu, nu, nb, n_rot;
    logic [11:0] bs;
    logic [11:0] bcds [2];
    logic [3:0]  prev_en;
    int          run_len;
    bit          seen_tr;

    vecs[0] = '{9'd511, 12'h511};
    vecs[1] = '{9'd7,   12'h007};
    vecs[2] = '{9'd137, 12'h137};
    vecs[3] = '{9'd255, 12'h255};
    vecs[4] = '{9'd100, 12'h100};
    vecs[5] = '{9'd99,  12'h099};
    vecs[6] = '{9'd0,   12'h000};
    vecs[7] = '{9'd10,  12'h010};
    vecs[8] = '{9'd400, 12'h400};
    vecs[9] = '{9'd256, 12'h256};

    // Reset state
    rst = 1'b1; count = '0; led_in = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_upd", 32'(upd), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_seg_en", 32'(seg_en), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // count held at 0: no conversion
    nu = 0; nb = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (upd) nu++;
      if (busy) nb++;
    end
    check("idle_upd_cnt", 32'(nu), 32'd0);
    check("idle_busy_cnt", 32'(nb), 32'd0);
    check("idle_bcd", 32'(bcd), 32'h000);

    // Conversion table
    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].cnt, fu, nu, nb, bs);
      check($sformatf("vec%0d_bcd", i), 32'(bs), 32'(vecs[i].exp_bcd));
      check($sformatf("vec%0d_upd_edge", i), 32'(fu), 32'd12);
      check($sformatf("vec%0d_upd_cnt", i), 32'(nu), 32'd1);
      check($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'd10);
      check($sformatf("vec%0d_bcd_hold", i), 32'(bcd), 32'(vecs[i].exp_bcd));
    end

    // Scan of 137, with and without the decimal point
    run_conv(9'd137, fu, nu, nb, bs);
    check("scan_bcd", 32'(bs), 32'h137);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      led_in = (pass == 0);
      @(posedge clk); #1;
      prev_en = seg_en;
      run_len = 1;
      seen_tr = 1'b0;
      n_rot = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        check("scan_onehot", 32'($onehot(seg_en)), 32'd1);
        check("scan_seg", 32'(seg), 32'(exp_seg(seg_en, led_in)));
        if (seg_en != prev_en) begin
          check("scan_rotate", 32'(seg_en), 32'({prev_en[2:0], prev_en[3]}));
          if (seen_tr) check("scan_period", 32'(run_len), 32'(SCAN_DIV));
          seen_tr = 1'b1;
          run_len = 1;
          n_rot++;
        end else begin
          run_len++;
        end
        prev_en = seg_en;
      end
      check("scan_steps", 32'(n_rot), 32'd10);
    end

    // 255 then 256 during the 5th CONV cycle: two pulses in order
    @(negedge clk);
    count = 9'd255;
    nu = 0;
    bcds[0] = 'x; bcds[1] = 'x;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 6) begin
        @(negedge clk);
        count = 9'd256;
      end else if (upd) begin
        if (nu < 2) bcds[nu] = bcd;
        nu++;
      end
    end
    check("chg_upd_cnt", 32'(nu), 32'd2);
    check("chg_bcd_first", 32'(bcds[0]), 32'h255);
    check("chg_bcd_second", 32'(bcds[1]), 32'h256);

    // Async reset mid-conversion
    @(negedge clk);
    count = 9'd300;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_upd", 32'(upd), 32'd0);
    check("arst_bcd", 32'(bcd), 32'h0);
    check("arst_seg", 32'(seg), 32'h0);
    check("arst_seg_en", 32'(seg_en), 32'h0);
    count = 9'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_seg_en", 32'(seg_en), 32'b0001);
    nu = 0; nb = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (upd) nu++;
      if (busy) nb++;
    end
    check("rel_idle_upd", 32'(nu), 32'd0);
    check("rel_idle_busy", 32'(nb), 32'd0);
    run_conv(9'd42, fu, nu, nb, bs);
    check("rel_bcd", 32'(bs), 32'h042);
    check("rel_upd_edge", 32'(fu), 32'd12);
    check("rel_upd_cnt", 32'(nu), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
